input_stream_buffer: RTL

Parametrised successor of the core input memory. Packs narrow chunks from the high-speed input port into activation words and stores them in a circular window of runtime-selectable depth. It gives the PE array control a 1-cycle read port with per-address hit/stall indication. Input uses a valid/ready handshake; consumed rows are freed explicitly, so overwrite is occupancy-driven rather than address-guessed.

---
 rtl/input_buffer_pkg.sv | 21 ++
 rtl/input_stream_buffer_if.sv | 12 +
 rtl/input_stream_buffer_chunk_packer.sv | 56 +++++
 rtl/input_stream_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/input_buffer_pkg.sv
// Shared constants and width helpers for the input stream buffer.
// FSM encodings plus row-address / count / chunk-index width functions.
package input_buffer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_FILL   = 2'd1;
  localparam state_t S_STREAM = 2'd2;

  // Row address width.
  function automatic int addr_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Width able to hold 0..rows inclusive.
  function automatic int cnt_w(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/input_stream_buffer_if.sv
// Chunk input handshake: valid/ready plus IN_WIDTH data.
// master = chunk source, slave = buffer.
interface input_stream_buffer_if #(
  parameter int IN_WIDTH = 8
);
  logic                valid;
  logic                ready;
  logic [IN_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/input_stream_buffer_chunk_packer.sv
// Chunk packer: tracks chunk index, builds lane-masked write data.
// Ports: clear_i, beat_i, data_i, cfg_chunks_i -> wdata_o, wmask_o, complete_o.
module isb_chunk_packer
  import input_buffer_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int WORD_WIDTH = 64,
  parameter int CCW        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  beat_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic [CCW-1:0]        cfg_chunks_i,
  output logic [WORD_WIDTH-1:0] wdata_o,
  output logic [WORD_WIDTH-1:0] wmask_o,
  output logic                  complete_o
);

  logic [CCW-1:0] idx_q, idx_d;
  logic           last;

  assign last       = (idx_q == cfg_chunks_i - CCW'(1));
  assign complete_o = beat_i && last;

  always_comb begin
    idx_d = idx_q;
    if (clear_i)
      idx_d = '0;
    else if (beat_i)
      idx_d = last ? '0 : idx_q + CCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  // Chunk 0 owns the whole word so stale upper bits get zeroed.
  always_comb begin
    wdata_o = '0;
    wmask_o = '0;
    if (idx_q == '0) begin
      wdata_o = WORD_WIDTH'(data_i);
      wmask_o = '1;
    end else begin
      wdata_o = WORD_WIDTH'(data_i) << (int'(idx_q) * IN_WIDTH);
      wmask_o = WORD_WIDTH'({IN_WIDTH{1'b1}})
                << (int'(idx_q) * IN_WIDTH);
    end
  end

endmodule

// File: rtl/input_stream_buffer.sv
// Circular activation-word buffer with chunk packing and hit-checked read.
// Ports: start/stop/cfg_*, in_if (slave), rd_*, release_i, ready/count/done.
// Optional: INPUT_STREAM_BUFFER_STALL_CNT_EN adds stall_cycles_o[15:0].
module input_stream_buffer
  import input_buffer_pkg::*;
#(
  parameter  int NUM_ROWS    = 32,
  parameter  int IN_WIDTH    = 8,
  parameter  int WORD_WIDTH  = 64,
  parameter  int TOTAL_WIDTH = 16,
  localparam int CHUNKS_MAX  = WORD_WIDTH / IN_WIDTH,
  localparam int AW          = addr_w(NUM_ROWS),
  localparam int CW          = cnt_w(NUM_ROWS),
  localparam int CCW         = cnt_w(CHUNKS_MAX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [CW-1:0]          cfg_window_i,
  input  logic [CW-1:0]          cfg_fill_rows_i,
  input  logic [CCW-1:0]         cfg_chunks_i,
  input  logic [TOTAL_WIDTH-1:0] cfg_total_words_i,
  input_stream_buffer_if.slave   in_if,
  input  logic                   rd_en_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [WORD_WIDTH-1:0]  rd_data_o,
  output logic                   rd_hit_o,
  input  logic                   release_i,
  output logic                   ready_o,
  output logic [CW-1:0]          count_o,
`ifdef INPUT_STREAM_BUFFER_STALL_CNT_EN
  output logic [15:0]            stall_cycles_o,
`endif
  output logic                   input_done_o
);

  state_t                 state_q, state_d;
  logic [CW-1:0]          win_q, fill_q;
  logic [CCW-1:0]         chunks_q;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic [TOTAL_WIDTH-1:0] words_q, words_d;
  logic [AW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          old_q, old_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   rdy_q, rdy_d;
  logic [WORD_WIDTH-1:0]  rdata_q;
  logic [WORD_WIDTH-1:0]  mem [NUM_ROWS];

  logic                   in_rdy, acc, cmp, rel, ctl;
  logic [WORD_WIDTH-1:0]  wdata, wmask;
  logic [CW-1:0]          ra, ro, off;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p,
    input logic [CW-1:0] w
  );
    return (CW'(p) == w - CW'(1)) ? '0 : p + AW'(1);
  endfunction

  // Registered-only: no path from in_if.valid.
  assign in_rdy = (state_q != S_IDLE) && (cnt_q < win_q) && !done_q;
  assign in_if.ready = in_rdy;

  assign ctl = start_i || stop_i;
  assign acc = in_if.valid && in_rdy && !ctl;
  assign rel = release_i && (cnt_q != '0) && !ctl;

  isb_chunk_packer #(
    .IN_WIDTH   (IN_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .CCW        (CCW)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (ctl),
    .beat_i       (acc),
    .data_i       (in_if.data),
    .cfg_chunks_i (chunks_q),
    .wdata_o      (wdata),
    .wmask_o      (wmask),
    .complete_o   (cmp)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    old_d   = old_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    done_d  = done_q;
    rdy_d   = rdy_q;
    if (ctl) begin
      state_d = stop_i ? S_IDLE : S_FILL;
      wr_d    = '0;
      old_d   = '0;
      cnt_d   = '0;
      words_d = '0;
      done_d  = 1'b0;
      rdy_d   = 1'b0;
    end else begin
      if (cmp)
        wr_d = bump(wr_q, win_q);
      if (rel)
        old_d = bump(old_q, win_q);
      if (cmp && !rel)
        cnt_d = cnt_q + CW'(1);
      else if (rel && !cmp)
        cnt_d = cnt_q - CW'(1);
      if (cmp) begin
        words_d = words_q + TOTAL_WIDTH'(1);
        if (total_q != '0 && words_d == total_q)
          done_d = 1'b1;
      end
      unique case (1'b1)
        state_q == S_FILL:
          if (cnt_d >= fill_q)
            state_d = S_STREAM;
        default: ;
      endcase
      // Underrun only counts while more input is still expected.
      rdy_d = (state_d == S_STREAM) && !(cnt_d == '0 && !done_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      fill_q   <= '0;
      chunks_q <= '0;
      total_q  <= '0;
      wr_q     <= '0;
      old_q    <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      if (start_i && !stop_i) begin
        win_q    <= cfg_window_i;
        fill_q   <= cfg_fill_rows_i;
        chunks_q <= cfg_chunks_i;
        total_q  <= cfg_total_words_i;
      end
      state_q <= state_d;
      wr_q    <= wr_d;
      old_q   <= old_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      mem[wr_q] <= (mem[wr_q] & ~wmask) | (wdata & wmask);
  end

  // Reads see the pre-write row on a same-cycle chunk write.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata_q <= '0;
    else if (rd_en_i)
      rdata_q <= mem[rd_addr_i];
  end

  assign ra  = CW'(rd_addr_i);
  assign ro  = CW'(old_q);
  assign off = (ra >= ro) ? ra - ro : ra + win_q - ro;

  assign rd_hit_o     = (off < cnt_q) && (ra < win_q);
  assign rd_data_o    = rdata_q;
  assign ready_o      = rdy_q;
  assign count_o      = cnt_q;
  assign input_done_o = done_q;

`ifdef INPUT_STREAM_BUFFER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_i)
      stall_q <= '0;
    else if (rd_en_i && !rd_hit_o && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
